ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, consuming operands and ops issued out of the ID/EX pipeline register.
- Holds the architectural HI/LO registers.
- Drives a stall back to the hazard logic, which deasserts the ID/EX write enable while a dependent instruction must wait.
- Iterative shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is verified.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend (forwarded RD1)
- rt_val  in  WIDTH  multiplier / divisor (forwarded RD2)
- hilo_wr  in  2  bit1 MTHI, bit0 MTLO
- hilo_wdata  in  WIDTH  data for MTHI/MTLO
- hilo_rd  in  1  EX-stage instruction is MFHI or MFLO
- busy  out  1  operation in progress
- stall  out  1  hold the pipeline (ID_EX_WR = ~stall)
- done  out  1  one-cycle pulse when the result lands in HI/LO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset, asynchronous, any state including mid-operation:
  - state IDLE; busy, done = 0; hi, lo = 0; iteration counter = 0.
  - Any in-flight operation is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - On a rising edge with issue_valid = 1, latch |rs| and |rt| (magnitudes only for signed ops), the op, and both operand signs.
  - Clear the counter; go to MUL (op[1] = 0) or DIV (op[1] = 1).
- MUL: 2*WIDTH-bit accumulator, one shift-add step per cycle. After WIDTH cycles (counter reaches WIDTH-1), go to FIX.
- DIV: restoring division, one quotient bit per cycle. After WIDTH cycles, go to FIX.
- FIX, one cycle:
  - Apply sign correction for signed ops:
    - product negated if the signs differ;
    - quotient negated if the signs differ;
    - remainder takes the dividend's sign.
  - Write HI/LO (MUL: HI = upper half, LO = lower half; DIV: HI = remainder, LO = quotient).
  - Go to IDLE; done = 1 in the following cycle only.
- Latency: the accept edge is cycle 0. busy = 1 for cycles 1..WIDTH+1 (33 cycles). hi/lo hold the new value and done = 1 in cycle WIDTH+2 (34).
- busy = 1 in MUL, DIV and FIX.
- stall is combinational: stall = busy & (issue_valid | hilo_rd | hilo_wr != 0).
  - Independent instructions proceed while busy.
  - MFHI/MFLO returns the final value once stall drops.
- issue_valid while busy is ignored; the pipeline holds it via stall and it is accepted the first IDLE cycle.
- Back-to-back: a new op can be accepted in the cycle done = 1.
- MTHI/MTLO:
  - Written at the edge when hilo_wr bit = 1 and state = IDLE, with no issue_valid in the same cycle.
  - While busy: ignored, with stall asserted.
  - Simultaneous issue_valid and hilo_wr in IDLE: the issue wins and the write is dropped (the decoder never produces this).
- Divide by zero, both DIV and DIVU: LO = all ones, HI = dividend as presented (rs_val). Same 33-cycle latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Operands are sampled only at the accept edge; later changes to rs_val/rt_val have no effect.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF
  - hi = 0xFFFFFFFE, lo = 0x00000001.
  - done high exactly in cycle 34 after the accept edge; busy high in cycles 1..33.
- MULT -3 x 5 (0xFFFFFFFD, 0x00000005) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
  - MULT 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU 7 / 2 -> lo = 3, hi = 1.
  - DIVU 5 / 0 -> lo = 0xFFFFFFFF, hi = 5.
- Hazards while busy:
  - hilo_rd = 1 during cycle 10 -> stall = 1 until done, and hi/lo read the new result.
  - Unrelated instruction (all request inputs low) -> stall = 0.
  - MTLO 0x1234 while busy -> ignored.
  - MTLO 0x1234 in IDLE -> lo = 0x1234 next cycle, hi unchanged.
- Second issue_valid held during busy -> accepted the cycle after the first result; two correct results on two done pulses, 34 cycles apart.
- rst pulsed mid-divide (cycle 15) -> busy, done, hi, lo = 0 immediately; a new DIVU 100 / 7 then yields lo = 14, hi = 2.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit: issue, HI/LO access and hazard stall.
interface ex_muldiv_if #(parameter int WIDTH = 32);
  logic             issue_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [1:0]       hilo_wr;
  logic [WIDTH-1:0] hilo_wdata;
  logic             hilo_rd;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output issue_valid, op, rs_val, rt_val, hilo_wr, hilo_wdata, hilo_rd,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  issue_valid, op, rs_val, rt_val, hilo_wr, hilo_wdata, hilo_rd,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; one bit per cycle, stalls dependent instructions.
//   state | meaning
//   IDLE  | HI/LO stable, accepts an issue or MTHI/MTLO
//   MUL   | shift-add step, WIDTH cycles
//   DIV   | restoring divide step, WIDTH cycles
//   FIX   | sign correction and HI/LO write-back
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               last_iter;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Signed ops run on magnitudes; the signs are reapplied in FIX.
  assign rs_neg = ~bus.op[0] & bus.rs_val[WIDTH-1];
  assign rt_neg = ~bus.op[0] & bus.rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};

  // Upper half of acc is the partial remainder, lower half shifts the dividend out and quotient in.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opb});
  assign div_rem   = div_ok ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];

  // With a zero divisor the remainder ends up as |rs|, so the sign fix restores rs as presented.
  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = div_zero ? {WIDTH{1'b1}}
                  : ((sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.issue_valid) state_nxt = bus.op[1] ? DIV : MUL;
      MUL:     if (last_iter) state_nxt = FIX;
      DIV:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            acc      <= {{WIDTH{1'b0}}, rs_mag};
            opb      <= rt_mag;
            is_div   <= bus.op[1];
            sign_a   <= rs_neg;
            sign_b   <= rt_neg;
            div_zero <= (bus.rt_val == '0);
            cnt      <= '0;
          end else begin
            if (bus.hilo_wr[1]) hi_q <= bus.hilo_wdata;
            if (bus.hilo_wr[0]) lo_q <= bus.hilo_wdata;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          acc <= {div_rem, acc[WIDTH-2:0], div_ok};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.issue_valid | bus.hilo_rd | (|bus.hilo_wr));
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: products, quotients, latency, hazards, MTHI/MTLO and reset.
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  ex_muldiv_if #(.WIDTH(32)) bus ();
  ex_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.op          = 2'b00;
    bus.rs_val      = '0;
    bus.rt_val      = '0;
    bus.hilo_wr     = 2'b00;
    bus.hilo_wdata  = '0;
    bus.hilo_rd     = 1'b0;
  endtask

  // Issues one op, scrambles the operands after the accept edge, returns the cycle done was seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output bit busy_ok);
    dcyc = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.op = o;
    bus.rs_val = a;
    bus.rt_val = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy !== (k <= 33)) busy_ok = 1'b0;
      if (k == 1) begin
        bus.issue_valid = 1'b0;
        bus.rs_val = 32'h5A5A_1234;
        bus.rt_val = 32'h0000_0003;
      end
      if (bus.done === 1'b1) begin
        dcyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++;
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    vectors++;
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
    rst = 1'b0;
    @(negedge clk);
    bus.hilo_rd = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", bus.stall); end
    bus.hilo_rd = 1'b0;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    bus.hilo_wr = 2'b10;
    bus.hilo_wdata = 32'hCAFE_0001;
    @(negedge clk);
    bus.hilo_wr = 2'b00;
    vectors++;
    if (bus.hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi: got %h expected cafe0001", bus.hi); end
    bus.hilo_wr = 2'b01;
    bus.hilo_wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hilo_wr = 2'b00;
    vectors++;
    if (bus.lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_lo: got %h expected 00001234", bus.lo); end
    vectors++;
    if (bus.hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected cafe0001", bus.hi); end
  endtask

  task automatic test_mul();
    vec_t tv[3];
    int   dcyc;
    bit   busy_ok;
    tv[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tv[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tv[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, dcyc, busy_ok);
      vectors++;
      if (dcyc != 34) begin errors++; $display("FAIL mul%0d_latency: got %0d expected 34", i, dcyc); end
      vectors++;
      if (!busy_ok) begin errors++; $display("FAIL mul%0d_busy: got wrong busy window expected cycles 1..33", i); end
      vectors++;
      if (bus.hi !== tv[i].hi) begin errors++; $display("FAIL mul%0d_hi: got %h expected %h", i, bus.hi, tv[i].hi); end
      vectors++;
      if (bus.lo !== tv[i].lo) begin errors++; $display("FAIL mul%0d_lo: got %h expected %h", i, bus.lo, tv[i].lo); end
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL mul%0d_done_pulse: got %b expected 0", i, bus.done); end
    end
  endtask

  task automatic test_div();
    vec_t tv[6];
    int   dcyc;
    bit   busy_ok;
    tv[0] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tv[1] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    tv[2] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    tv[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tv[4] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tv[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, dcyc, busy_ok);
      vectors++;
      if (dcyc != 34) begin errors++; $display("FAIL div%0d_latency: got %0d expected 34", i, dcyc); end
      vectors++;
      if (!busy_ok) begin errors++; $display("FAIL div%0d_busy: got wrong busy window expected cycles 1..33", i); end
      vectors++;
      if (bus.hi !== tv[i].hi) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, bus.hi, tv[i].hi); end
      vectors++;
      if (bus.lo !== tv[i].lo) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, bus.lo, tv[i].lo); end
    end
  endtask

  task automatic test_hazard();
    int dcyc = -1;
    bit stall_ok = 1'b1;
    @(negedge clk);
    bus.hilo_wr = 2'b01;
    bus.hilo_wdata = 32'h0000_0055;
    @(negedge clk);
    bus.hilo_wr = 2'b00;
    vectors++;
    if (bus.lo !== 32'h0000_0055) begin errors++; $display("FAIL haz_mtlo_idle: got %h expected 00000055", bus.lo); end
    bus.issue_valid = 1'b1;
    bus.op = 2'b01;
    bus.rs_val = 32'h0001_0000;
    bus.rt_val = 32'h0001_0003;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dcyc = k;
        break;
      end
      if (k == 1) bus.issue_valid = 1'b0;
      if (k == 3) begin
        bus.hilo_wr = 2'b01;
        bus.hilo_wdata = 32'h0000_1234;
        #1;
        vectors++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL haz_mtlo_stall: got %b expected 1", bus.stall); end
      end
      if (k == 4) bus.hilo_wr = 2'b00;
      if (k == 5) begin
        vectors++;
        if (bus.lo !== 32'h0000_0055) begin errors++; $display("FAIL haz_mtlo_busy_ignored: got %h expected 00000055", bus.lo); end
        vectors++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL haz_unrelated_stall: got %b expected 0", bus.stall); end
      end
      if (k == 10) begin
        bus.hilo_rd = 1'b1;
        #1;
      end
      if (k >= 10 && bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    vectors++;
    if (dcyc != 34) begin errors++; $display("FAIL haz_latency: got %0d expected 34", dcyc); end
    vectors++;
    if (!stall_ok) begin errors++; $display("FAIL haz_mfhi_stall: got a stall drop expected stall 1 in cycles 10..33"); end
    vectors++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL haz_stall_release: got %b expected 0", bus.stall); end
    vectors++;
    if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL haz_hi: got %h expected 00000001", bus.hi); end
    vectors++;
    if (bus.lo !== 32'h0003_0000) begin errors++; $display("FAIL haz_lo: got %h expected 00030000", bus.lo); end
    bus.hilo_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    bit stall_ok = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.op = 2'b11;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k <= 33 && bus.stall !== 1'b1) stall_ok = 1'b0;
      if (k == 1) begin
        bus.op = 2'b01;
        bus.rs_val = 32'h1234_5678;
        bus.rt_val = 32'h0000_0010;
      end
      if (d1 >= 0 && k == d1 + 1) bus.issue_valid = 1'b0;
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin
          d1 = k;
          vectors++;
          if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b expected 0", bus.stall); end
          vectors++;
          if (bus.hi !== 32'd2) begin errors++; $display("FAIL b2b_first_hi: got %h expected 00000002", bus.hi); end
          vectors++;
          if (bus.lo !== 32'd14) begin errors++; $display("FAIL b2b_first_lo: got %h expected 0000000e", bus.lo); end
        end else begin
          d2 = k;
          break;
        end
      end
    end
    vectors++;
    if (d1 != 34) begin errors++; $display("FAIL b2b_first_done: got %0d expected 34", d1); end
    vectors++;
    if (d2 != 68) begin errors++; $display("FAIL b2b_second_done: got %0d expected 68", d2); end
    vectors++;
    if (!stall_ok) begin errors++; $display("FAIL b2b_stall: got a stall drop expected stall 1 in cycles 1..33"); end
    vectors++;
    if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL b2b_second_hi: got %h expected 00000001", bus.hi); end
    vectors++;
    if (bus.lo !== 32'h2345_6780) begin errors++; $display("FAIL b2b_second_lo: got %h expected 23456780", bus.lo); end
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dcyc;
    bit busy_ok;
    @(negedge clk);
    bus.hilo_wr = 2'b11;
    bus.hilo_wdata = 32'h0000_AAAA;
    @(negedge clk);
    bus.hilo_wr = 2'b00;
    bus.issue_valid = 1'b1;
    bus.op = 2'b11;
    bus.rs_val = 32'hFFFF_FFFF;
    bus.rt_val = 32'h0000_0003;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) bus.issue_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    vectors++;
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", bus.hi); end
    vectors++;
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", bus.lo); end
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b11, 32'd100, 32'd7, dcyc, busy_ok);
    vectors++;
    if (dcyc != 34) begin errors++; $display("FAIL rstmid_latency: got %0d expected 34", dcyc); end
    vectors++;
    if (!busy_ok) begin errors++; $display("FAIL rstmid_busy_window: got wrong busy window expected cycles 1..33"); end
    vectors++;
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL rstmid_hi_after: got %h expected 00000002", bus.hi); end
    vectors++;
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL rstmid_lo_after: got %h expected 0000000e", bus.lo); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mthi_mtlo();
    test_mul();
    test_div();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
